reaction_session_ctrl: RTL and testbench

Session sequencer for the reaction-timer datapath. It runs a fixed number of trials back to back: resets and starts the timer, waits for each result, then classifies it and records it. It tracks the last, best and summed valid times plus the false-start count, and raises a summary flag when the session ends. It sits between the board buttons and the timer, and owns the timer's reset and start inputs.

---
 rtl/reaction_pkg.sv | 26 ++
 rtl/bcd_to_ms.sv | 16 +
 rtl/reaction_session_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_reaction_session_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// reaction_pkg
//   Shared definitions for the reaction-timer session sequencer:
//   state encoding, special timer result codes and the initial "best" value.
package reaction_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_START   = 3'd2,
        S_RUN     = 3'd3,
        S_CAPTURE = 3'd4,
        S_GAP     = 3'd5,
        S_SUMMARY = 3'd6
    } state_t;

    // Timer reports 9.999 s when the player pressed before the light.
    localparam logic [15:0] RESULT_FALSE       = 16'h9999;
    // Anything of one second or more is treated as a missed reaction.
    localparam logic [15:0] RESULT_TIMEOUT_MIN = 16'h1000;
    // Best starts at the largest BCD value so any valid result beats it.
    localparam logic [15:0] BEST_INIT          = 16'h9999;
    localparam logic [19:0] SUM_MAX            = 20'hFFFFF;

endpackage

// File: rtl/bcd_to_ms.sv
// bcd_to_ms
//   Combinational conversion of three BCD digits {d2,d1,d0} (the
//   millisecond part of a timer result) into a binary millisecond count.
//   Ports:
//     bcd  in  12  BCD digits, d2 in [11:8], d1 in [7:4], d0 in [3:0]
//     ms   out 10  d2*100 + d1*10 + d0 (0..999 for legal BCD)
module bcd_to_ms (
    input  logic [11:0] bcd,
    output logic [9:0]  ms
);

    always_comb begin
        ms = 10'(bcd[11:8]) * 10'd100 + 10'(bcd[7:4]) * 10'd10 + 10'(bcd[3:0]);
    end

endmodule

// File: rtl/reaction_session_ctrl.sv
// reaction_session_ctrl
//   Runs TRIALS reaction trials back to back: resets and starts the timer,
//   waits for each result, classifies it and keeps last/best/sum/false-start
//   statistics. Owns the timer's reset and start inputs.
//   Ports:
//     i_clk, i_reset_n        clock, synchronous active-low reset
//     i_go                    session start button (level, rising edge used)
//     i_abort                 return to IDLE on the next clock, wins always
//     o_tmr_reset/o_tmr_start timer control (start is a 1-cycle pulse)
//     i_tmr_done/i_tmr_result timer done level and BCD result
//     o_last/o_best/o_sum     last result, best valid result, sum in ms
//     o_trial/o_false         completed trials, false starts
//     o_busy/o_summary/o_wdog session running, finished, watchdog fired
//     o_state                 current FSM state (debug visibility)
//   Handshake: the timer is a level interface. i_tmr_done is only looked at
//   in RUN; a done level seen there moves to CAPTURE, where i_tmr_result is
//   taken. The timer is held in reset between trials, which drops done.
module reaction_session_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned TRIALS     = 4,
    parameter int unsigned GAP_TICKS  = 200_000_000,
    parameter int unsigned WDOG_TICKS = 1_600_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_go,
    input  logic        i_abort,
    output logic        o_tmr_reset,
    output logic        o_tmr_start,
    input  logic        i_tmr_done,
    input  logic [15:0] i_tmr_result,
    output logic [15:0] o_last,
    output logic [15:0] o_best,
    output logic [19:0] o_sum,
    output logic [3:0]  o_trial,
    output logic [3:0]  o_false,
    output logic        o_busy,
    output logic        o_summary,
    output logic        o_wdog,
    output logic [2:0]  o_state
);

    localparam logic [31:0] GAP_LAST  = 32'(GAP_TICKS - 1);
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_TICKS - 1);
    localparam logic [3:0]  TRIALS_N  = 4'(TRIALS);

    state_t      state;
    logic        go_q;
    logic        arm_cnt;
    logic [31:0] gap_cnt;
    logic [31:0] wdog_cnt;

    logic        go_edge;
    logic [9:0]  cap_ms;
    logic [20:0] sum_add;
    logic [19:0] sum_sat;
    logic [3:0]  trial_inc;
    logic        is_false;
    logic        is_timeout;

    bcd_to_ms u_bcd_to_ms (
        .bcd (i_tmr_result[11:0]),
        .ms  (cap_ms)
    );

    always_comb begin
        go_edge    = i_go & ~go_q;
        sum_add    = {1'b0, o_sum} + 21'(cap_ms);
        // Carry out of 20 bits means the sum would wrap; pin it instead.
        sum_sat    = sum_add[20] ? SUM_MAX : sum_add[19:0];
        trial_inc  = o_trial + 4'd1;
        is_false   = (i_tmr_result == RESULT_FALSE);
        is_timeout = (i_tmr_result >= RESULT_TIMEOUT_MIN);
    end

    assign o_state = state;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state       <= S_IDLE;
            go_q        <= 1'b1;   // a button held through reset is not an edge
            arm_cnt     <= 1'b0;
            gap_cnt     <= '0;
            wdog_cnt    <= '0;
            o_tmr_reset <= 1'b0;
            o_tmr_start <= 1'b0;
            o_last      <= '0;
            o_best      <= BEST_INIT;
            o_sum       <= '0;
            o_trial     <= '0;
            o_false     <= '0;
            o_busy      <= 1'b0;
            o_summary   <= 1'b0;
            o_wdog      <= 1'b0;
        end else begin
            go_q        <= i_go;
            // Both timer controls are pulses unless a state re-asserts them.
            o_tmr_start <= 1'b0;
            o_tmr_reset <= 1'b0;

            if (i_abort) begin
                state       <= S_IDLE;
                o_tmr_reset <= 1'b1;
                o_busy      <= 1'b0;
                o_summary   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_SUMMARY: begin
                        if (go_edge) begin
                            o_last      <= '0;
                            o_best      <= BEST_INIT;
                            o_sum       <= '0;
                            o_trial     <= '0;
                            o_false     <= '0;
                            o_summary   <= 1'b0;
                            o_wdog      <= 1'b0;
                            o_busy      <= 1'b1;
                            o_tmr_reset <= 1'b1;
                            arm_cnt     <= 1'b0;
                            state       <= S_ARM;
                        end
                    end

                    S_ARM: begin
                        // Timer reset is already high for this cycle; keep it
                        // for one more, then fire start on the way out.
                        if (!arm_cnt) begin
                            arm_cnt     <= 1'b1;
                            o_tmr_reset <= 1'b1;
                        end else begin
                            o_tmr_start <= 1'b1;
                            state       <= S_START;
                        end
                    end

                    S_START: begin
                        wdog_cnt <= '0;
                        state    <= S_RUN;
                    end

                    S_RUN: begin
                        if (i_tmr_done) begin
                            state <= S_CAPTURE;
                        end else if (wdog_cnt == WDOG_LAST) begin
                            o_wdog      <= 1'b1;
                            o_tmr_reset <= 1'b1;
                            o_busy      <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            wdog_cnt <= wdog_cnt + 32'd1;
                        end
                    end

                    S_CAPTURE: begin
                        o_last  <= i_tmr_result;
                        o_trial <= trial_inc;
                        if (is_false) begin
                            o_false <= o_false + 4'd1;
                        end else if (!is_timeout) begin
                            o_sum <= sum_sat;
                            if (i_tmr_result < o_best) begin
                                o_best <= i_tmr_result;
                            end
                        end
                        if (trial_inc == TRIALS_N) begin
                            o_summary <= 1'b1;
                            o_busy    <= 1'b0;
                            state     <= S_SUMMARY;
                        end else begin
                            gap_cnt     <= '0;
                            o_tmr_reset <= 1'b1;
                            state       <= S_GAP;
                        end
                    end

                    S_GAP: begin
                        // Reset stays high for the whole gap; the next trial
                        // goes straight to START without re-arming.
                        if (gap_cnt == GAP_LAST) begin
                            o_tmr_start <= 1'b1;
                            state       <= S_START;
                        end else begin
                            gap_cnt     <= gap_cnt + 32'd1;
                            o_tmr_reset <= 1'b1;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reaction_session_ctrl.sv
module tb_reaction_session_ctrl;
  import reaction_pkg::*;

  localparam int TRIALS = 2;
  localparam int GAP    = 5;
  localparam int WDOG   = 10;
  localparam int EXP_W  = 63;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        go, abort, tmr_done;
  logic [15:0] tmr_result;
  logic        tmr_reset, tmr_start;
  logic [15:0] o_last, o_best;
  logic [19:0] o_sum;
  logic [3:0]  o_trial, o_false;
  logic        o_busy, o_summary, o_wdog;
  logic [2:0]  o_state;

  reaction_session_ctrl #(
    .TRIALS     (TRIALS),
    .GAP_TICKS  (GAP),
    .WDOG_TICKS (WDOG)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_go         (go),
    .i_abort      (abort),
    .o_tmr_reset  (tmr_reset),
    .o_tmr_start  (tmr_start),
    .i_tmr_done   (tmr_done),
    .i_tmr_result (tmr_result),
    .o_last       (o_last),
    .o_best       (o_best),
    .o_sum        (o_sum),
    .o_trial      (o_trial),
    .o_false      (o_false),
    .o_busy       (o_busy),
    .o_summary    (o_summary),
    .o_wdog       (o_wdog),
    .o_state      (o_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [15:0]      tmr_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack_exp(
    input logic [15:0] last, input logic [15:0] best, input logic [19:0] sum,
    input logic [3:0] trial, input logic [3:0] fls,
    input logic summary, input logic busy, input logic wdog);
    return {last, best, sum, trial, fls, summary, busy, wdog};
  endfunction

  // ---------------- timer model ----------------
  // After a start pulse, returns the next queued result 3 cycles later and
  // holds done until reset. With an empty queue it never finishes.
  logic tmr_pend;
  int   tmr_wait;
  initial begin
    tmr_done   = 1'b0;
    tmr_result = 16'h0000;
    tmr_pend   = 1'b0;
    tmr_wait   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tmr_reset) begin
        tmr_done = 1'b0;
        tmr_pend = 1'b0;
      end else if (tmr_start) begin
        if (tmr_q.size() > 0) begin
          tmr_result = tmr_q.pop_front();
          tmr_pend   = 1'b1;
          tmr_wait   = 3;
        end
      end else if (tmr_pend) begin
        tmr_wait--;
        if (tmr_wait == 0) begin
          tmr_done = 1'b1;
          tmr_pend = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  // A record is due whenever a trial is captured or the watchdog fires.
  logic [3:0] prev_trial = 4'd0;
  logic       prev_wdog  = 1'b0;
  always @(negedge clk) begin
    logic [EXP_W-1:0] got, want;
    if (rst_n === 1'b1) begin
      if ((o_trial != prev_trial && o_trial != 4'd0) || (o_wdog && !prev_wdog)) begin
        got = {o_last, o_best, o_sum, o_trial, o_false, o_summary, o_busy, o_wdog};
        if (exp_q.size() == 0) begin
          check("unexpected_record", 64'(got), 64'(0));
        end else begin
          want = exp_q.pop_front();
          check("record", 64'(got), 64'(want));
        end
      end
    end
    prev_trial = o_trial;
    prev_wdog  = o_wdog;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_state(input state_t s, input int max, input string name);
    int n = 0;
    while (o_state !== s && n < max) begin
      step();
      n++;
    end
    check(name, 64'(o_state), 64'(s));
  endtask

  // Rising edge on go, then check the ARM/START/RUN cadence cycle by cycle.
  task automatic issue_go();
    go = 1'b0;
    step();
    go = 1'b1;
    step();                                   // cycle +1
    go = 1'b0;
    check("go_p1_arm", 64'({o_state, tmr_reset, tmr_start, o_busy}), 64'({S_ARM, 1'b1, 1'b0, 1'b1}));
    step();                                   // cycle +2
    check("go_p2_reset", 64'({tmr_reset, tmr_start}), 64'({1'b1, 1'b0}));
    step();                                   // cycle +3
    check("go_p3_start", 64'({o_state, tmr_reset, tmr_start}), 64'({S_START, 1'b0, 1'b1}));
    step();                                   // cycle +4
    check("go_p4_run", 64'({o_state, tmr_start}), 64'({S_RUN, 1'b0}));
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  // ---------------- watchdog on the bench itself ----------------
  initial begin
    #200000;
    $display("FAIL bench_timeout: actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    go    = 1'b1;   // held through reset release
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) step();

    check("reset_state", 64'(o_state), 64'(S_IDLE));
    check("reset_best", 64'(o_best), 64'(16'h9999));
    check("reset_busy", 64'(o_busy), 64'(0));
    check("reset_others",
          64'({o_last, o_sum, o_trial, o_false, o_summary, o_wdog, tmr_reset, tmr_start}), 64'(0));

    // Session 1: 0.245 then 0.198
    tmr_q.push_back(16'h0245);
    tmr_q.push_back(16'h0198);
    exp_q.push_back(pack_exp(16'h0245, 16'h0245, 20'd245, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(pack_exp(16'h0198, 16'h0198, 20'd443, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0));
    issue_go();
    wait_state(S_CAPTURE, 50, "s1_capture");
    n = 0;
    while (tmr_start !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("gap_to_start", 64'(n), 64'(GAP + 1));
    wait_state(S_SUMMARY, 100, "s1_summary_state");
    check("s1_summary_flag", 64'({o_summary, o_busy}), 64'({1'b1, 1'b0}));

    // Session 2: false start then 0.300 (started from SUMMARY)
    tmr_q.push_back(16'h9999);
    tmr_q.push_back(16'h0300);
    exp_q.push_back(pack_exp(16'h9999, 16'h9999, 20'd0, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(pack_exp(16'h0300, 16'h0300, 20'd300, 4'd2, 4'd1, 1'b1, 1'b0, 1'b0));
    issue_go();
    wait_state(S_SUMMARY, 100, "s2_summary_state");

    // Session 3: timeout result then false start; best/sum untouched
    tmr_q.push_back(16'h1000);
    tmr_q.push_back(16'h9999);
    exp_q.push_back(pack_exp(16'h1000, 16'h9999, 20'd0, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(pack_exp(16'h9999, 16'h9999, 20'd0, 4'd2, 4'd1, 1'b1, 1'b0, 1'b0));
    issue_go();
    wait_state(S_SUMMARY, 100, "s3_summary_state");

    // Session 4: timer never finishes -> watchdog
    exp_q.push_back(pack_exp(16'h0000, 16'h9999, 20'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    issue_go();
    n = 0;
    while (o_state !== S_IDLE && n < 50) begin
      step();
      n++;
    end
    check("wdog_latency", 64'(n), 64'(WDOG));
    check("wdog_tmr_reset", 64'({tmr_reset, o_wdog}), 64'({1'b1, 1'b1}));
    step();
    check("wdog_reset_pulse_end", 64'(tmr_reset), 64'(0));

    // Session 5: abort during GAP after one capture
    tmr_q.push_back(16'h0123);
    tmr_q.push_back(16'h0456);
    exp_q.push_back(pack_exp(16'h0123, 16'h0123, 20'd123, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0));
    issue_go();
    wait_state(S_GAP, 50, "s5_gap_state");
    pulse_abort();
    check("abort_gap_idle",
          64'({o_state, tmr_reset, o_busy, o_trial, o_wdog}), 64'({S_IDLE, 1'b1, 1'b0, 4'd1, 1'b0}));
    tmr_q.delete();
    repeat (GAP + 5) step();
    check("abort_gap_stays", 64'({o_state, o_trial, o_last}), 64'({S_IDLE, 4'd1, 16'h0123}));

    // Session 6: abort in the same cycle as done -> no capture
    tmr_q.push_back(16'h0777);
    issue_go();
    n = 0;
    while (tmr_done !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("s6_done_seen", 64'(tmr_done), 64'(1));
    pulse_abort();
    check("abort_done_idle",
          64'({o_state, o_trial, o_last, o_sum}), 64'({S_IDLE, 4'd0, 16'h0000, 20'd0}));
    repeat (5) step();
    check("abort_done_no_capture", 64'({o_state, o_trial, o_last}), 64'({S_IDLE, 4'd0, 16'h0000}));

    // Session 7: go toggled while busy has no effect
    tmr_q.push_back(16'h0111);
    tmr_q.push_back(16'h0222);
    exp_q.push_back(pack_exp(16'h0111, 16'h0111, 20'd111, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(pack_exp(16'h0222, 16'h0111, 20'd333, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0));
    issue_go();
    for (int i = 0; i < 3; i++) begin
      go = 1'b1;
      step();
      go = 1'b0;
      step();
    end
    wait_state(S_SUMMARY, 100, "s7_summary_state");

    // Abort from SUMMARY drops the flag but keeps statistics
    pulse_abort();
    check("abort_summary",
          64'({o_state, o_summary, o_trial, o_sum}), 64'({S_IDLE, 1'b0, 4'd2, 20'd333}));

    repeat (5) step();
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
